mc_control_unit: RTL and testbench

//  Multi-cycle MIPS controller: Moore FSM that sequences the shared datapath (PC, IR, GPR, ALU, DM) of
//  the multi-cycle CPU, one instruction over 3-5 clocks. Sits beside the datapath in mc_cpu; sees only
//  IR opcode/funct and ALU zero. Drives all enables/selects, counts retired instructions, traps illegal ops.

---
 rtl/mc_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS controller.
// Moore FSM that sequences the shared PC/IR/GPR/ALU/DM datapath one
// instruction at a time, counts retired instructions and traps illegal ops.
module mc_control_unit #(
    parameter int unsigned RETIRE_W        = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                pc_write,
    output logic                pc_en,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                dm_read,
    output logic                dm_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_op,
    output logic [2:0]          alu_ctrl,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXE   = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_I_EXE   = 4'd10,
        S_I_WB    = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    state_e              state_q, state_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                pc_write_cond;
    logic                funct_ok;
    logic [2:0]          r_alu_ctrl;
    state_e              illegal_next;

    assign illegal_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;

    // R-type funct decode: ALU operation and whether the funct is supported.
    always_comb begin
        funct_ok   = 1'b1;
        r_alu_ctrl = ALU_ADD;
        case (funct)
            FN_ADD, FN_ADDU: r_alu_ctrl = ALU_ADD;
            FN_SUB, FN_SUBU: r_alu_ctrl = ALU_SUB;
            FN_AND:          r_alu_ctrl = ALU_AND;
            FN_OR:           r_alu_ctrl = ALU_OR;
            FN_SLT:          r_alu_ctrl = ALU_SLT;
            default:         funct_ok   = 1'b0;
        endcase
    end

    // Next state, sticky illegal flag and retire counter update.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEM_ADR;
                    OP_RTYPE:                          state_d = S_R_EXE;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = S_I_EXE;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = illegal_next;
                    end
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_R_EXE: begin
                if (funct_ok) begin
                    state_d = S_R_WB;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = illegal_next;
                end
            end
            S_I_EXE:   state_d = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + RETIRE_W'(1);
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // State, illegal flag and retire counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Moore output decode; everything is held at 0 while reset is low so
    // no enable or select leaks out of an aborted instruction.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        dm_read       = 1'b0;
        dm_write      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_op        = 1'b0;
        alu_ctrl      = ALU_ADD;
        pc_source     = 2'b00;
        halted        = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    ext_op    = 1'b1;
                end
                S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 1'b1;
                end
                S_MEM_RD:  dm_read = 1'b1;
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR:  dm_write = 1'b1;
                S_R_EXE: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu_ctrl;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ctrl      = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_EXE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ADDI, OP_ADDIU: ext_op   = 1'b1;
                        OP_ORI:            alu_ctrl = ALU_OR;
                        OP_LUI:            alu_ctrl = ALU_LUI;
                        default:           alu_ctrl = ALU_ADD;
                    endcase
                end
                S_I_WB:    reg_write = 1'b1;
                S_HALT:    halted    = 1'b1;
                default:   halted    = 1'b0;
            endcase
        end
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed and randomized instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_control_unit;

    logic        clock;
    logic        rst0, rst1;
    logic [5:0]  opcode, funct;
    logic        zero;

    logic        pc_write0, pc_en0, ir_write0, reg_write0, reg_dst0, mem_to_reg0;
    logic        dm_read0, dm_write0, alu_src_a0, ext_op0, halted0, illegal0;
    logic [1:0]  alu_src_b0, pc_source0;
    logic [2:0]  alu_ctrl0;
    logic [3:0]  state0;
    logic [31:0] retired0;

    logic        pc_write1, pc_en1, ir_write1, reg_write1, reg_dst1, mem_to_reg1;
    logic        dm_read1, dm_write1, alu_src_a1, ext_op1, halted1, illegal1;
    logic [1:0]  alu_src_b1, pc_source1;
    logic [2:0]  alu_ctrl1;
    logic [3:0]  state1;
    logic [31:0] retired1;

    logic [17:0] vec0, vec1;

    int          errors = 0;
    int          checks = 0;
    int unsigned ret_model = 0;
    bit          ill_model = 0;

    mc_control_unit #(.RETIRE_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clock(clock), .reset(rst0), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write0), .pc_en(pc_en0), .ir_write(ir_write0), .reg_write(reg_write0),
        .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .dm_read(dm_read0), .dm_write(dm_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .ext_op(ext_op0), .alu_ctrl(alu_ctrl0),
        .pc_source(pc_source0), .state(state0), .halted(halted0), .illegal(illegal0),
        .retired(retired0)
    );

    mc_control_unit #(.RETIRE_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clock(clock), .reset(rst1), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write1), .pc_en(pc_en1), .ir_write(ir_write1), .reg_write(reg_write1),
        .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .dm_read(dm_read1), .dm_write(dm_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .ext_op(ext_op1), .alu_ctrl(alu_ctrl1),
        .pc_source(pc_source1), .state(state1), .halted(halted1), .illegal(illegal1),
        .retired(retired1)
    );

    assign vec0 = {pc_write0, pc_en0, ir_write0, reg_write0, reg_dst0, mem_to_reg0, dm_read0,
                   dm_write0, alu_src_a0, alu_src_b0, ext_op0, alu_ctrl0, pc_source0, halted0};
    assign vec1 = {pc_write1, pc_en1, ir_write1, reg_write1, reg_dst1, mem_to_reg1, dm_read1,
                   dm_write1, alu_src_a1, alu_src_b1, ext_op1, alu_ctrl1, pc_source1, halted1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic bit op_is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                          6'b001000, 6'b001001, 6'b001101, 6'b001111};
    endfunction

    function automatic bit fn_is_legal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                          6'b100101, 6'b101010};
    endfunction

    // Expected output vector for a given step code of an instruction.
    function automatic logic [17:0] exp_out(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
        logic pw, pe, irw, rw, rd, m2r, dr, dw, sa, ex, h;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pw, pe, irw, rw, rd, m2r, dr, dw, sa, ex, h} = '0;
        sb = 2'd0; ps = 2'd0; ac = 3'd0;
        case (st)
            0:  begin pw = 1; pe = 1; irw = 1; sb = 2'd1; end
            1:  begin sb = 2'd3; ex = 1; end
            2:  begin sa = 1; sb = 2'd2; ex = 1; end
            3:  dr = 1;
            4:  begin rw = 1; m2r = 1; end
            5:  dw = 1;
            6:  begin
                    sa = 1;
                    if (fn == 6'b100010 || fn == 6'b100011) ac = 3'd1;
                    else if (fn == 6'b100100) ac = 3'd2;
                    else if (fn == 6'b100101) ac = 3'd3;
                    else if (fn == 6'b101010) ac = 3'd4;
                end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ac = 3'd1; ps = 2'd1; pe = z; end
            9:  begin pw = 1; pe = 1; ps = 2'd2; end
            10: begin
                    sa = 1; sb = 2'd2;
                    if (op == 6'b001000 || op == 6'b001001) ex = 1;
                    else if (op == 6'b001101) ac = 3'd3;
                    else if (op == 6'b001111) ac = 3'd5;
                end
            11: rw = 1;
            12: h = 1;
            default: ;
        endcase
        return {pw, pe, irw, rw, rd, m2r, dr, dw, sa, sb, ex, ac, ps, h};
    endfunction

    // Runs one instruction on dut0 starting at a negedge in FETCH; checks
    // every cycle and the retire/illegal bookkeeping afterwards.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int  seq[$];
        bit  legal;
        logic [17:0] e;
        opcode = op; funct = fn; zero = z;
        seq = '{0, 1};
        legal = 1;
        if (!op_is_legal(op)) legal = 0;
        else if (op == 6'b100011) seq = '{0, 1, 2, 3, 4};
        else if (op == 6'b101011) seq = '{0, 1, 2, 5};
        else if (op == 6'b000000) begin
            if (fn_is_legal(fn)) seq = '{0, 1, 6, 7};
            else begin seq = '{0, 1, 6}; legal = 0; end
        end
        else if (op == 6'b000100) seq = '{0, 1, 8};
        else if (op == 6'b000010) seq = '{0, 1, 9};
        else seq = '{0, 1, 10, 11};
        foreach (seq[i]) begin
            e = exp_out(seq[i], op, fn, z);
            checks++;
            if (state0 !== 4'(seq[i])) begin
                errors++;
                $display("FAIL state op=%b fn=%b step=%0d: got %0d want %0d", op, fn, i, state0, seq[i]);
            end
            checks++;
            if (vec0 !== e) begin
                errors++;
                $display("FAIL outputs op=%b fn=%b state=%0d: got %h want %h", op, fn, seq[i], vec0, e);
            end
            @(posedge clock); @(negedge clock);
        end
        if (legal) ret_model++;
        else ill_model = 1;
        checks++;
        if (retired0 !== ret_model) begin
            errors++;
            $display("FAIL retired op=%b: got %0d want %0d", op, retired0, ret_model);
        end
        checks++;
        if (illegal0 !== ill_model) begin
            errors++;
            $display("FAIL illegal op=%b fn=%b: got %b want %b", op, fn, illegal0, ill_model);
        end
        checks++;
        if (state0 !== 4'd0) begin
            errors++;
            $display("FAIL back_to_fetch op=%b: got %0d want 0", op, state0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst0 = 0; rst1 = 0; opcode = '0; funct = '0; zero = 0;
        @(negedge clock);
        checks++;
        if (state0 !== 4'd0 || state1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d want 0", state0, state1);
        end
        checks++;
        if (vec0 !== 18'h0 || vec1 !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h want 0", vec0, vec1);
        end
        checks++;
        if (retired0 !== 32'd0 || illegal0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: got retired=%0d illegal=%b want 0/0", retired0, illegal0);
        end
        rst0 = 1;
        #1;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'd0, 1'b0);
    endtask

    task automatic test_sw_addu();
        run_instr(6'b101011, 6'd0, 1'b0);
        run_instr(6'b000000, 6'b100001, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'd0, 1'b1);
        run_instr(6'b000100, 6'd0, 1'b0);
    endtask

    task automatic test_illegal_skip();
        run_instr(6'b111111, 6'd0, 1'b0);
    endtask

    task automatic test_bad_funct();
        run_instr(6'b000000, 6'b000000, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        logic [5:0] fns [8];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                6'b001000, 6'b001001, 6'b001101, 6'b001111, 6'b000000};
        fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 7)];
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011; funct = '0; zero = 0;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        checks++;
        if (state0 !== 4'd3 || illegal0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_precond: got state=%0d illegal=%b want 3/1", state0, illegal0);
        end
        #2 rst0 = 0;
        #1;
        checks++;
        if (state0 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got %0d want 0", state0);
        end
        checks++;
        if (vec0 !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h want 0", vec0);
        end
        checks++;
        if (retired0 !== 32'd0 || illegal0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_counters: got %0d/%b want 0/0", retired0, illegal0);
        end
        ret_model = 0; ill_model = 0;
    endtask

    task automatic test_trap();
        opcode = 6'b111111; funct = '0; zero = 0;
        @(negedge clock);
        rst1 = 1;
        #1;
        checks++;
        if (state1 !== 4'd0) begin
            errors++;
            $display("FAIL trap_fetch: got %0d want 0", state1);
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if (state1 !== 4'd1) begin
            errors++;
            $display("FAIL trap_decode: got %0d want 1", state1);
        end
        for (int k = 0; k < 11; k++) begin
            @(posedge clock); @(negedge clock);
            checks++;
            if (state1 !== 4'd12 || vec1 !== exp_out(12, opcode, funct, zero)) begin
                errors++;
                $display("FAIL trap_halt cycle %0d: got state=%0d out=%h want 12/%h",
                         k, state1, vec1, exp_out(12, opcode, funct, zero));
            end
            checks++;
            if (illegal1 !== 1'b1 || retired1 !== 32'd0) begin
                errors++;
                $display("FAIL trap_flags cycle %0d: got illegal=%b retired=%0d want 1/0",
                         k, illegal1, retired1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_addu();
        test_beq();
        test_illegal_skip();
        test_bad_funct();
        test_random();
        test_reset_mid();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
